spi_tx_fifo: RTL
================

// Module: spi_tx_fifo
// PURPOSE
//  Word buffer directly upstream of the SPI master. Producers push WORD_WIDTH-bit words with a
//  valid/ready handshake. The SPI shifter pops them through a second valid/ready handshake.
//  It decouples bursty producers from the serial link, and reports fill level and protocol
//  errors to the controlling logic.
// PARAMETERS
//  WORD_WIDTH   8   width of one buffered word (equals SPI word_width)
//  DEPTH_LOG2   2   log2 of storage depth; DEPTH = 2**DEPTH_LOG2 entries, DEPTH_LOG2 >= 1
//  AF_LEVEL     3   almost_full_o asserts when count_o >= AF_LEVEL; range 1..DEPTH
// PORTS
//  clk_i          in   1               clock, all state updates on rising edge
//  rst_i          in   1               asynchronous reset, active-high
//  flush_i        in   1               synchronous clear of contents and error flags
//  wr_valid_i     in   1               producer offers wr_data_i
//  wr_data_i      in   WORD_WIDTH      word to store
//  wr_ready_o     out  1               buffer can accept a word this cycle
//  rd_valid_o     out  1               rd_data_o holds the oldest stored word
//  rd_data_o      out  WORD_WIDTH      oldest word (first-word fall-through)
//  rd_ready_i     in   1               SPI shifter takes rd_data_o this cycle
//  count_o        out  DEPTH_LOG2+1    number of stored words, 0..DEPTH
//  almost_full_o  out  1               count_o >= AF_LEVEL
//  overflow_o     out  1               sticky: a write was attempted while wr_ready_o = 0
// BEHAVIOUR
//  - Reset (async, rst_i = 1): both pointers = 0, count_o = 0, wr_ready_o = 1, rd_valid_o = 0,
//    almost_full_o = 0, overflow_o = 0, rd_data_o = 0. Storage contents are don't-care.
//  - Pointers are DEPTH_LOG2+1 bits and wrap modulo 2*DEPTH.
//  - count_o = wr_ptr - rd_ptr. empty: count_o == 0. full: count_o == DEPTH.
//  - wr_ready_o = !full, rd_valid_o = !empty. Both are combinational from registered pointers
//    and do not depend on the current-cycle inputs.
//  - Write fires when wr_valid_i & wr_ready_o: mem[wr_ptr] <= wr_data_i, wr_ptr++.
//  - Read fires when rd_valid_o & rd_ready_i: rd_ptr++.
//  - rd_data_o = mem[rd_ptr[DEPTH_LOG2-1:0]] while rd_valid_o = 1; it is 0 while empty.
//  - Latency: a word written on edge N is visible on rd_data_o, with rd_valid_o = 1, after
//    edge N. There is no same-cycle bypass from wr_data_i to rd_data_o.
//  - Simultaneous read and write when neither empty nor full: both fire, count unchanged.
//  - Full with rd_ready_i = 1: the read fires, but the write is refused (wr_ready_o was 0).
//    Next cycle count = DEPTH-1.
//  - Empty with wr_valid_i = 1: the write fires, nothing is read. Next cycle count = 1.
//  - Overflow: wr_valid_i & !wr_ready_o sets overflow_o on the next edge. It holds until
//    flush_i or rst_i. The offered data is dropped and no state other than overflow_o changes.
//  - A read request while empty is ignored silently; no state changes.
//  - flush_i = 1: pointers <= 0 and overflow_o <= 0. Flush has priority over a write or read
//    in the same cycle, and neither of those takes effect. Outputs read as empty after the edge.
//  - Reset asserted mid-operation: immediate return to reset values, stored words are lost.
//    After release, the first write behaves as if into a fresh buffer.
//  - almost_full_o is derived from the registered count_o, with no extra latency.
// TESTING
//  1. Reset, then write 0xA1,0xB2,0xC3,0xD4 with rd_ready_i=0 -> count_o 1,2,3,4; almost_full_o
//     rises at count 3; wr_ready_o=0 at count 4; rd_data_o=0xA1 throughout.
//  2. Full, then wr_valid_i=1 with 0xEE for one cycle -> overflow_o=1 next cycle, count_o stays 4,
//     drain yields A1,B2,C3,D4 only; overflow_o stays 1 until flush_i.
//  3. Count 2, then wr_valid_i=rd_ready_i=1 for 10 cycles with incrementing data -> count_o
//     stays 2; read order equals write order across pointer wrap-around.
//  4. Empty, then write 0x5A on edge N -> rd_valid_o=0 before N, rd_valid_o=1 and rd_data_o=0x5A
//     after N. rd_ready_i=1 while empty -> count_o stays 0.
//  5. Count 3, then assert flush_i together with a write and a read -> next cycle count_o=0,
//     rd_valid_o=0, overflow_o=0, wr_ready_o=1.
//  6. Count 3, then pulse rst_i between clock edges -> outputs reach reset values before the
//     next edge; a later write of 0x11 reads back as 0x11 with count_o=1.

Source files
------------

// File: rtl/spi_tx_fifo.sv
// Word FIFO between producers and the SPI shifter, with first-word fall-through read,
// fill level, almost-full and sticky overflow reporting.
module spi_tx_fifo #(
  parameter int unsigned WORD_WIDTH = 8,
  parameter int unsigned DEPTH_LOG2 = 2,
  parameter int unsigned AF_LEVEL   = 3
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  flush_i,
  input  logic                  wr_valid_i,
  input  logic [WORD_WIDTH-1:0] wr_data_i,
  output logic                  wr_ready_o,
  output logic                  rd_valid_o,
  output logic [WORD_WIDTH-1:0] rd_data_o,
  input  logic                  rd_ready_i,
  output logic [DEPTH_LOG2:0]   count_o,
  output logic                  almost_full_o,
  output logic                  overflow_o
);

  localparam int unsigned Depth = 1 << DEPTH_LOG2;
  localparam int unsigned PtrW  = DEPTH_LOG2 + 1;
  localparam logic [PtrW-1:0] DepthCnt = PtrW'(Depth);
  localparam logic [PtrW-1:0] AfCnt    = PtrW'(AF_LEVEL);

  logic [WORD_WIDTH-1:0] mem_q [Depth];
  logic [PtrW-1:0]       wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]       rd_ptr_q, rd_ptr_d;
  logic                  overflow_q, overflow_d;
  logic [PtrW-1:0]       count;
  logic                  full, empty;
  logic                  wr_fire, rd_fire;

  // Extra pointer bit distinguishes full from empty when the index bits match.
  assign count = wr_ptr_q - rd_ptr_q;
  assign full  = (count == DepthCnt);
  assign empty = (count == '0);

  assign wr_ready_o    = ~full;
  assign rd_valid_o    = ~empty;
  assign count_o       = count;
  assign almost_full_o = (count >= AfCnt);
  assign overflow_o    = overflow_q;
  assign rd_data_o     = empty ? '0 : mem_q[rd_ptr_q[DEPTH_LOG2-1:0]];

  assign wr_fire = wr_valid_i & ~full & ~flush_i;
  assign rd_fire = rd_ready_i & ~empty & ~flush_i;

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    overflow_d = overflow_q;
    if (flush_i) begin
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      overflow_d = 1'b0;
    end else begin
      if (wr_fire) wr_ptr_d = wr_ptr_q + 1'b1;
      if (rd_fire) rd_ptr_d = rd_ptr_q + 1'b1;
      if (wr_valid_i && full) overflow_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      overflow_q <= overflow_d;
    end
  end

  // Storage needs no reset; empty masks stale contents on rd_data_o.
  always_ff @(posedge clk_i) begin
    if (wr_fire) mem_q[wr_ptr_q[DEPTH_LOG2-1:0]] <= wr_data_i;
  end

endmodule
